intr_request_ctrl: RTL and testbench

//  Front end for the external interrupt lines of the CPU datapath.
//  - Synchronises and debounces three raw push-button requests.
//  - Converts each clean press into a sticky pending level on irq[i], which drives the CPU's IRA/IRB/IRC inputs.
//  - Holds each level until the CPU's clear code (clrNo) names that source.
//  - Counts presses lost because their source was still pending.

---
 rtl/intr_request_ctrl_pkg.sv | 24 ++
 rtl/intr_request_ctrl_if.sv | 30 +++
 rtl/intr_request_ctrl_btn_debounce.sv | 103 ++++++++++
 rtl/intr_request_ctrl.sv | 66 ++++++
 tb/tb_intr_request_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/intr_request_ctrl_pkg.sv
// Shared definitions for the interrupt request front end: clear codes,
// debounce state encoding and the clear-code decode helper.
package intr_pkg;

  localparam logic [1:0] CLR_NONE = 2'd0;
  localparam logic [1:0] CLR_A    = 2'd1;
  localparam logic [1:0] CLR_B    = 2'd2;
  localparam logic [1:0] CLR_C    = 2'd3;

  localparam int unsigned DROP_W = 8;

  typedef enum logic [1:0] {
    DB_LOW  = 2'd0,
    DB_RISE = 2'd1,
    DB_HIGH = 2'd2,
    DB_FALL = 2'd3
  } db_state_e;

  // Code i+1 names source i; CLR_NONE never matches any source.
  function automatic logic clr_hit(input logic [1:0] code, input int unsigned idx);
    return (code != CLR_NONE) && (code == 2'(idx + 1));
  endfunction

endpackage

// File: rtl/intr_request_ctrl_if.sv
// Request/clear/status bundle between the board-level stimulus side (master)
// and the interrupt request controller (slave).
interface intr_request_ctrl_if #(
  parameter int N_SRC = 3
);
  import intr_pkg::*;

  logic [N_SRC-1:0]  btn_raw;
  logic [1:0]        clr_no;
  logic [N_SRC-1:0]  irq;
  logic [N_SRC-1:0]  press;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output btn_raw,
    output clr_no,
    input  irq,
    input  press,
    input  drop_cnt
  );

  modport slave (
    input  btn_raw,
    input  clr_no,
    output irq,
    output press,
    output drop_cnt
  );

endinterface

// File: rtl/intr_request_ctrl_btn_debounce.sv
// One push-button channel: 2-flop synchroniser, debounce FSM and stability
// counter, emitting a single registered pulse per accepted press.
//
// state   | meaning
// DB_LOW  | button settled released
// DB_RISE | saw a high level, waiting for it to stay stable
// DB_HIGH | button settled pressed, press already reported
// DB_FALL | saw a low level, waiting for it to stay stable
module btn_debounce
  import intr_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int CNT_W        = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= DB_LOW;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    meta_d  = raw;
    sync_d  = meta_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;

    case (state_q)
      DB_LOW: begin
        cnt_d = '0;
        if (sync_q) begin
          state_d = DB_RISE;
        end
      end

      DB_RISE: begin
        if (!sync_q) begin
          state_d = DB_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_HIGH;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DB_HIGH: begin
        cnt_d = '0;
        if (!sync_q) begin
          state_d = DB_FALL;
        end
      end

      DB_FALL: begin
        // A release must settle fully before the next press can arm.
        if (sync_q) begin
          state_d = DB_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = DB_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign press = press_q;

endmodule

// File: rtl/intr_request_ctrl.sv
// Interrupt request front end: debounced button presses become sticky irq
// levels, cleared by the CPU clear code, with a saturating lost-press count.
module intr_request_ctrl
  import intr_pkg::*;
#(
  parameter int N_SRC        = 3,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int CNT_W        = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  intr_request_ctrl_if.slave   bus
);

  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  logic [N_SRC-1:0]  press_w;
  logic [N_SRC-1:0]  clr_vec;
  logic [N_SRC-1:0]  irq_q, irq_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              drop;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.btn_raw[g]),
      .press (press_w[g])
    );
  end

  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr_vec[i] = clr_hit(bus.clr_no, i);
    end
  end

  // A press in the clear cycle wins and is not counted as lost.
  always_comb begin
    irq_d      = press_w | (irq_q & ~clr_vec);
    drop       = |(press_w & irq_q & ~clr_vec);
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != DROP_MAX)) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      irq_q      <= irq_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.irq      = irq_q;
  assign bus.press    = press_w;
  assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_intr_request_ctrl.sv
// Directed bench for intr_request_ctrl with DEBOUNCE_CYC=4: expected press
// pulses are queued at drive time and matched when the DUT emits them.
module tb_intr_request_ctrl;

  localparam int N_SRC   = 3;
  localparam int DB_CYC  = 4;
  localparam int LAT     = DB_CYC + 3;

  typedef struct {
    logic [N_SRC-1:0] mask;
    int               cyc;
  } press_exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   exp_drop;
  press_exp_t exp_q[$];

  intr_request_ctrl_if #(.N_SRC(N_SRC)) bus ();

  intr_request_ctrl #(
    .N_SRC        (N_SRC),
    .DEBOUNCE_CYC (DB_CYC),
    .CNT_W        (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a clean press on mask, hold it, release and let the channel settle.
  task automatic clean_press(input logic [N_SRC-1:0] mask);
    press_exp_t e;
    tick(1);
    bus.btn_raw = bus.btn_raw | mask;
    e.mask = mask;
    e.cyc  = cyc + LAT;
    exp_q.push_back(e);
    tick(8);
    bus.btn_raw = bus.btn_raw & ~mask;
    tick(10);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && cyc == exp_q[0].cyc) begin
      chk("press_pulse", 32'(bus.press), 32'(exp_q[0].mask));
      void'(exp_q.pop_front());
    end else if (bus.press != '0) begin
      chk("press_unexpected", 32'(bus.press), 32'd0);
    end
  end

  initial begin
    press_exp_t e;
    n_cmp    = 0;
    n_err    = 0;
    exp_drop = 0;
    rst_n       = 1'b0;
    bus.btn_raw = 3'b111;
    bus.clr_no  = 2'd0;

    // Reset with all buttons held
    tick(3);
    @(negedge clk);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    chk("rst_press", 32'(bus.press), 32'd0);
    chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
    tick(1);
    rst_n       = 1'b1;
    bus.btn_raw = 3'b000;
    tick(8);
    @(negedge clk);
    chk("post_rst_irq", 32'(bus.irq), 32'd0);

    // Reset in the middle of a debounce abandons it
    tick(1);
    bus.btn_raw = 3'b001;
    tick(4);
    rst_n = 1'b0;
    tick(2);
    bus.btn_raw = 3'b000;
    rst_n       = 1'b1;
    tick(10);
    @(negedge clk);
    chk("mid_rst_irq", 32'(bus.irq), 32'd0);

    // Clean press on source 0 with exact latency
    tick(1);
    bus.btn_raw = 3'b001;
    e.mask = 3'b001;
    e.cyc  = cyc + LAT;
    exp_q.push_back(e);
    tick(LAT);
    @(negedge clk);
    chk("irq0_not_yet", 32'(bus.irq), 32'd0);
    tick(1);
    @(negedge clk);
    chk("irq0_set", 32'(bus.irq), 32'b001);
    tick(12);
    bus.btn_raw = 3'b000;
    tick(10);
    @(negedge clk);
    chk("irq0_held", 32'(bus.irq), 32'b001);

    // Bounce on source 1 is rejected
    for (int i = 0; i < 2; i++) begin
      tick(1);
      bus.btn_raw[1] = 1'b1;
      tick(1);
      bus.btn_raw[1] = 1'b0;
      tick(1);
    end
    tick(10);
    @(negedge clk);
    chk("bounce_irq", 32'(bus.irq), 32'b001);
    chk("bounce_queue", 32'(exp_q.size()), 32'd0);

    // Clear decode
    clean_press(3'b010);
    @(negedge clk);
    chk("irq_011", 32'(bus.irq), 32'b011);
    tick(1);
    bus.clr_no = 2'd2;
    tick(1);
    @(negedge clk);
    chk("clr_b", 32'(bus.irq), 32'b001);
    bus.clr_no = 2'd3;
    tick(1);
    @(negedge clk);
    chk("clr_c_idle", 32'(bus.irq), 32'b001);
    bus.clr_no = 2'd0;
    tick(2);
    @(negedge clk);
    chk("clr_none", 32'(bus.irq), 32'b001);

    // Lost press while pending
    clean_press(3'b100);
    @(negedge clk);
    chk("irq_101", 32'(bus.irq), 32'b101);
    chk("drop_0", 32'(bus.drop_cnt), 32'd0);
    clean_press(3'b100);
    exp_drop = 1;
    @(negedge clk);
    chk("drop_1", 32'(bus.drop_cnt), 32'(exp_drop));
    chk("drop_irq", 32'(bus.irq), 32'b101);

    // Press in the same cycle as its clear: set wins, no drop
    tick(1);
    bus.btn_raw = 3'b100;
    e.mask = 3'b100;
    e.cyc  = cyc + LAT;
    exp_q.push_back(e);
    tick(LAT);
    bus.clr_no = 2'd3;
    tick(1);
    bus.clr_no = 2'd0;
    @(negedge clk);
    chk("set_wins_irq", 32'(bus.irq), 32'b101);
    chk("set_wins_drop", 32'(bus.drop_cnt), 32'(exp_drop));
    tick(1);
    bus.btn_raw = 3'b000;
    tick(10);

    // Clear held: only the press cycle shows irq
    bus.clr_no = 2'd1;
    tick(2);
    @(negedge clk);
    chk("held_clr", 32'(bus.irq), 32'b100);
    tick(1);
    bus.btn_raw = 3'b001;
    e.mask = 3'b001;
    e.cyc  = cyc + LAT;
    exp_q.push_back(e);
    tick(LAT + 1);
    @(negedge clk);
    chk("held_clr_set", 32'(bus.irq), 32'b101);
    tick(1);
    @(negedge clk);
    chk("held_clr_gone", 32'(bus.irq), 32'b100);
    bus.btn_raw = 3'b000;
    tick(10);
    bus.clr_no = 2'd0;
    @(negedge clk);
    chk("held_clr_drop", 32'(bus.drop_cnt), 32'(exp_drop));

    // Simultaneous drops count once, saturating at FF
    clean_press(3'b011);
    @(negedge clk);
    chk("both_pending", 32'(bus.irq), 32'b111);
    chk("both_no_drop", 32'(bus.drop_cnt), 32'(exp_drop));
    for (int i = 0; i < 256; i++) begin
      clean_press(3'b011);
      exp_drop = (exp_drop == 255) ? 255 : exp_drop + 1;
      @(negedge clk);
      chk("drop_sat", 32'(bus.drop_cnt), 32'(exp_drop));
    end
    chk("drop_final", 32'(bus.drop_cnt), 32'hFF);
    chk("irq_final", 32'(bus.irq), 32'b111);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
